// File: rtl/spi_master_if.sv
// Bus bundle between the SPI master and its user/slave side.
// The master modport is the DUT view; slave is the driver/observer view.
interface spi_master_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] data_tx;
  logic [31:0] data_rx;
  logic [1:0]  transaction_length;
  logic        CPOL;
  logic        CPHA;
  logic        MOSI;
  logic        MISO;
  logic        SPI_SCLK;
  logic        CS;

  modport master (
    input  start, data_tx, transaction_length, CPOL, CPHA, MISO,
    output busy, done, data_rx, MOSI, SPI_SCLK, CS
  );

  modport slave (
    output start, data_tx, transaction_length, CPOL, CPHA, MISO,
    input  busy, done, data_rx, MOSI, SPI_SCLK, CS
  );
endinterface

// File: rtl/spi_master.sv
// SPI master, modes 0-3, 8/16/24/32-bit words, MSB first, all outputs registered.
// Frame: SETUP (CLK_DIV) + N SCLK periods (2*CLK_DIV each) + HOLD (CLK_DIV).
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, SETUP, TRANSFER, HOLD} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic        ph_q, ph_d;
  logic [31:0] tx_q, tx_d, rx_q, rx_d, data_rx_q, data_rx_d;
  logic [1:0]  len_q, len_d;
  logic        cpol_q, cpol_d, cpha_q, cpha_d;
  logic        sclk_q, sclk_d, cs_q, cs_d, busy_q, busy_d, done_q, done_d, mosi_q, mosi_d;
  logic [31:0] tx_aligned;
  logic        div_end, last_bit, do_shift, do_sample;

  assign div_end    = (cnt_q == DIV_LAST);
  assign last_bit   = (bit_q == {len_q, 3'b111});
  // Left-align the word so the outgoing bit is always tx_q[31].
  assign tx_aligned = bus.data_tx << {~bus.transaction_length, 3'b000};

  always_comb begin
    state_d   = state_q;
    cnt_d     = div_end ? 8'd0 : cnt_q + 8'd1;
    bit_d     = bit_q;
    ph_d      = ph_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    data_rx_d = data_rx_q;
    len_d     = len_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    mosi_d    = mosi_q;
    do_shift  = 1'b0;
    do_sample = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        bit_d  = '0;
        ph_d   = 1'b0;
        sclk_d = bus.CPOL;
        cs_d   = 1'b1;
        busy_d = 1'b0;
        mosi_d = 1'b0;
        // A start coinciding with done is dropped; the next cycle may start.
        if (bus.start && !done_q) begin
          state_d = SETUP;
          len_d   = bus.transaction_length;
          cpol_d  = bus.CPOL;
          cpha_d  = bus.CPHA;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          rx_d    = '0;
          if (!bus.CPHA) begin
            mosi_d = tx_aligned[31];
            tx_d   = tx_aligned << 1;
          end else begin
            tx_d   = tx_aligned;
          end
        end
      end
      SETUP: begin
        if (div_end) begin
          state_d   = TRANSFER;
          sclk_d    = ~cpol_q;
          ph_d      = 1'b0;
          bit_d     = '0;
          do_shift  = cpha_q;
          do_sample = ~cpha_q;
        end
      end
      TRANSFER: begin
        if (div_end) begin
          if (!ph_q) begin
            sclk_d    = cpol_q;
            ph_d      = 1'b1;
            do_sample = cpha_q;
            do_shift  = ~cpha_q & ~last_bit;
          end else if (last_bit) begin
            state_d = HOLD;
          end else begin
            sclk_d    = ~cpol_q;
            ph_d      = 1'b0;
            bit_d     = bit_q + 5'd1;
            do_shift  = cpha_q;
            do_sample = ~cpha_q;
          end
        end
      end
      HOLD: begin
        if (div_end) begin
          state_d   = IDLE;
          cs_d      = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          data_rx_d = rx_q;
          sclk_d    = cpol_q;
          mosi_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_shift) begin
      mosi_d = tx_q[31];
      tx_d   = {tx_q[30:0], 1'b0};
    end
    if (do_sample) rx_d = {rx_q[30:0], bus.MISO};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      ph_q      <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      data_rx_q <= '0;
      len_q     <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      ph_q      <= ph_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      data_rx_q <= data_rx_d;
      len_q     <= len_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mosi_q    <= mosi_d;
    end
  end

  assign bus.SPI_SCLK = sclk_q;
  assign bus.CS       = cs_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.MOSI     = mosi_q;
  assign bus.data_rx  = data_rx_q;
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: CLK_DIV=2 main instance with loopback/slave
// monitor, plus a CLK_DIV=1 instance for the fastest-divider corner.
module tb_spi_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_if bus();
  spi_master_if bus1();

  spi_master #(.CLK_DIV(2)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  spi_master #(.CLK_DIV(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic loop_en = 1'b1;
  logic slv_en  = 1'b0;
  logic slv_miso = 1'b0;
  assign bus.MISO  = slv_en ? slv_miso : (loop_en ? bus.MOSI : 1'b0);
  assign bus1.MISO = bus1.MOSI;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Bus monitor and mode-3 slave (drives next MISO bit on each leading edge).
  int          cs_low_tot = 0, done_tot = 0, pulse_tot = 0, mosi_bad = 0;
  logic [31:0] mosi_stream = '0;
  logic [31:0] slv_sr = 32'h12345678;
  logic        prev_sclk = 1'b0, prev_mosi = 1'b0, prev_cs = 1'b1;
  logic        mon_cpol = 1'b0, mon_cpha = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (!bus.CS) cs_low_tot <= cs_low_tot + 1;
      if (bus.done) done_tot <= done_tot + 1;
      if (!bus.CS && bus.SPI_SCLK != prev_sclk) begin
        if (bus.SPI_SCLK != mon_cpol) begin
          pulse_tot <= pulse_tot + 1;
          if (!mon_cpha) mosi_stream <= {mosi_stream[30:0], bus.MOSI};
          slv_miso <= slv_sr[31];
          slv_sr   <= {slv_sr[30:0], 1'b0};
        end else if (mon_cpha) begin
          mosi_stream <= {mosi_stream[30:0], bus.MOSI};
        end
      end
      if (bus.CS) slv_sr <= 32'h12345678;
      if (!bus.CS && !prev_cs && bus.MOSI != prev_mosi && !(bus.SPI_SCLK && !prev_sclk))
        mosi_bad <= mosi_bad + 1;
    end
    prev_sclk <= bus.SPI_SCLK;
    prev_mosi <= bus.MOSI;
    prev_cs   <= bus.CS;
  end

  int s_cs, s_done, s_pulse, s_bad;

  task automatic start_xfer(input logic cpol, input logic cpha, input logic [1:0] len,
                            input logic [31:0] tx);
    @(negedge clk);
    bus.CPOL = cpol; bus.CPHA = cpha; bus.transaction_length = len; bus.data_tx = tx;
    mon_cpol = cpol; mon_cpha = cpha;
    repeat (3) @(negedge clk);
    chk("idle_sclk", 32'(bus.SPI_SCLK), 32'(cpol));
    chk("idle_cs", 32'(bus.CS), 32'd1);
    s_cs = cs_low_tot; s_done = done_tot; s_pulse = pulse_tot; s_bad = mosi_bad;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("cs_low", 32'(bus.CS), 32'd0);
    chk("busy", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_done(input bit pulse, output int cyc);
    cyc = 1;
    while (!bus.done && cyc < 400) begin
      bus.start = pulse && (cyc % 3 == 0);
      if (pulse) begin
        bus.data_tx = ~bus.data_tx;
        bus.transaction_length = 2'(cyc);
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    chk("done_seen", 32'(bus.done), 32'd1);
  endtask

  task automatic check_end(input logic [31:0] exp_rx, input int exp_cyc, input int cyc,
                           input int n, input logic cpol);
    chk("cycles", 32'(cyc), 32'(exp_cyc));
    chk("rx", bus.data_rx, exp_rx);
    chk("done_cs", 32'(bus.CS), 32'd1);
    chk("done_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("done_cnt", 32'(done_tot - s_done), 32'd1);
    chk("pulses", 32'(pulse_tot - s_pulse), 32'(n));
    chk("cs_time", 32'(cs_low_tot - s_cs), 32'(exp_cyc - 1));
    chk("post_sclk", 32'(bus.SPI_SCLK), 32'(cpol));
    chk("done_1cyc", 32'(bus.done), 32'd0);
    chk("rx_hold", bus.data_rx, exp_rx);
  endtask

  task automatic run1(input logic cpol, input logic cpha, input logic [1:0] len,
                      input logic [31:0] tx, input int exp_cyc);
    int cyc;
    @(negedge clk);
    bus1.CPOL = cpol; bus1.CPHA = cpha; bus1.transaction_length = len; bus1.data_tx = tx;
    repeat (2) @(negedge clk);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    cyc = 1;
    while (!bus1.done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("div1_cycles", 32'(cyc), 32'(exp_cyc));
    chk("div1_rx", bus1.data_rx, tx);
  endtask

  initial begin
    int cyc;
    bus.start = 1'b0; bus.data_tx = '0; bus.transaction_length = '0;
    bus.CPOL = 1'b0; bus.CPHA = 1'b0;
    bus1.start = 1'b0; bus1.data_tx = '0; bus1.transaction_length = '0;
    bus1.CPOL = 1'b0; bus1.CPHA = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(bus.CS), 32'd1);
    chk("rst_sclk", 32'(bus.SPI_SCLK), 32'd0);
    chk("rst_mosi", 32'(bus.MOSI), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_rx", bus.data_rx, 32'd0);
    rst = 1'b0;

    // Mode 0, 8 bits, loopback
    start_xfer(1'b0, 1'b0, 2'b00, 32'h000000A5);
    wait_done(1'b0, cyc);
    check_end(32'h000000A5, 37, cyc, 8, 1'b0);
    chk("mosi_a5", 32'(mosi_stream[7:0]), 32'hA5);

    // Start on the done cycle is dropped
    start_xfer(1'b0, 1'b0, 2'b00, 32'h0000003C);
    wait_done(1'b0, cyc);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("rx_3c", bus.data_rx, 32'h3C);
    repeat (3) @(negedge clk);
    chk("start_on_done_cs", 32'(bus.CS), 32'd1);
    chk("start_on_done_busy", 32'(bus.busy), 32'd0);

    // Mode 3, 32 bits, external slave
    slv_en = 1'b1;
    start_xfer(1'b1, 1'b1, 2'b11, 32'hDEADBEEF);
    wait_done(1'b0, cyc);
    check_end(32'h12345678, 133, cyc, 32, 1'b1);
    chk("mosi_deadbeef", mosi_stream, 32'hDEADBEEF);
    slv_en = 1'b0;

    // Mode 1, 16 bits, loopback; MOSI may only move with rising SCLK
    start_xfer(1'b0, 1'b1, 2'b01, 32'h0000C3C3);
    wait_done(1'b0, cyc);
    check_end(32'h0000C3C3, 69, cyc, 16, 1'b0);
    chk("mosi_c3c3", 32'(mosi_stream[15:0]), 32'hC3C3);
    chk("mosi_on_rise", 32'(mosi_bad - s_bad), 32'd0);

    // 24 bits with start pulses and input churn while busy
    start_xfer(1'b0, 1'b0, 2'b10, 32'h00ABCDEF);
    wait_done(1'b1, cyc);
    check_end(32'h00ABCDEF, 101, cyc, 24, 1'b0);
    repeat (5) @(negedge clk);
    chk("one_done", 32'(done_tot - s_done), 32'd1);
    chk("no_restart", 32'(bus.CS), 32'd1);

    // Reset 10 cycles into a 32-bit mode-3 transfer
    start_xfer(1'b1, 1'b1, 2'b11, 32'hFFFF0000);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_cs", 32'(bus.CS), 32'd1);
    chk("abort_sclk", 32'(bus.SPI_SCLK), 32'd0);
    chk("abort_rx", bus.data_rx, 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_no_done", 32'(done_tot - s_done), 32'd0);
    start_xfer(1'b0, 1'b0, 2'b00, 32'h0000005A);
    wait_done(1'b0, cyc);
    check_end(32'h0000005A, 37, cyc, 8, 1'b0);

    // Mode 2, MISO tied low
    loop_en = 1'b0;
    start_xfer(1'b1, 1'b0, 2'b00, 32'h000000FF);
    wait_done(1'b0, cyc);
    check_end(32'h00000000, 37, cyc, 8, 1'b1);
    chk("mosi_ff", 32'(mosi_stream[7:0]), 32'hFF);
    loop_en = 1'b1;

    // CLK_DIV=1 corner
    run1(1'b0, 1'b0, 2'b00, 32'h0000003C, 19);
    run1(1'b1, 1'b1, 2'b11, 32'h80000001, 67);
    run1(1'b0, 1'b1, 2'b10, 32'h00F0A50F, 51);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk cycles, legal range 1..255.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle transfer request.
REQ-005 SHALL have port busy  output  1  transfer in progress.
REQ-006 SHALL have port done  output  1  one-cycle pulse at transfer end.
REQ-007 SHALL have port data_tx  input  32  word to send; bits [N-1:0] used.
REQ-008 SHALL have port data_rx  output  32  received word, zero-extended.
REQ-009 SHALL have port transaction_length  input  2  00=8, 01=16, 10=24, 11=32 bits (N).
REQ-010 SHALL have port CPOL  input  1  SCLK idle level.
REQ-011 SHALL have port CPHA  input  1  0: sample on leading edge; 1: sample on trailing edge.
REQ-012 SHALL have port MOSI  output  1  serial data out, MSB first.
REQ-013 SHALL have port MISO  input  1  serial data in, MSB first.
REQ-014 SHALL have port SPI_SCLK  output  1  serial clock.
REQ-015 SHALL have port CS  output  1  active-low chip select.

Function
REQ-016 SHALL implement states IDLE, SETUP, TRANSFER, HOLD; every output registered.
REQ-017 In IDLE: CS=1, busy=0, MOSI=0, SPI_SCLK tracks CPOL with one-cycle register delay.
REQ-018 start=1 in IDLE SHALL latch data_tx, transaction_length, CPOL, CPHA; next cycle CS=0, busy=1, state SETUP.
REQ-019 start while busy SHALL be ignored; input changes while busy SHALL NOT affect the transfer.
REQ-020 On entry to SETUP with CPHA=0, MOSI SHALL equal latched data_tx[N-1].
REQ-021 SETUP SHALL last CLK_DIV cycles with SCLK at CPOL, then go to TRANSFER.
REQ-022 TRANSFER SHALL produce exactly N SCLK periods, each 2*CLK_DIV cycles: CLK_DIV at the non-idle level, then CLK_DIV at CPOL.
REQ-023 CPHA=0: sample MISO on each leading edge; shift MOSI to the next bit on each trailing edge except the last.
REQ-024 CPHA=1: shift MOSI to the next bit on each leading edge (first leading edge presents bit N-1); sample MISO on each trailing edge.
REQ-025 After the N-th trailing edge SHALL enter HOLD for CLK_DIV cycles with SCLK=CPOL and MOSI held.
REQ-026 At HOLD exit, same cycle: CS=1, busy=0, done=1, data_rx = received bits in [N-1:0], upper bits 0; state IDLE.
REQ-027 data_rx SHALL update only on done and otherwise hold its value.
REQ-028 Total CS-low time SHALL be CLK_DIV*(2N+2) cycles.
REQ-029 start asserted in the same cycle as done SHALL be ignored; a new transfer can begin from the following cycle.
REQ-030 Bit counter and divider counter SHALL wrap cleanly; no extra or missing SCLK edges for any N or CLK_DIV.

Reset
REQ-031 rst=1 SHALL immediately force CS=1, SPI_SCLK=0, MOSI=0, busy=0, done=0, data_rx=0, state IDLE, counters 0.
REQ-032 rst asserted mid-transfer SHALL abort the transfer without a done pulse; data_rx SHALL read 0.
REQ-033 After rst deasserts, the first transfer SHALL behave identically to one after power-up.

Verification
REQ-034 CLK_DIV=2, mode 0 (CPOL=0, CPHA=0), len=00, data_tx=0x000000A5, MISO looped to MOSI, start at cycle k -> CS low cycles k+1..k+36, 8 SCLK pulses, done at k+37, data_rx=0x000000A5.
REQ-035 Mode 3, len=11, data_tx=0xDEADBEEF, MISO from an external slave model returning 0x12345678 -> MOSI bit stream 0xDEADBEEF MSB-first, data_rx=0x12345678, 32 SCLK periods, SCLK idles high.
REQ-036 Mode 1, len=01, data_tx=0x0000C3C3, loopback -> data_rx=0x0000C3C3; MOSI changes only on rising SCLK, MISO sampled on falling SCLK.
REQ-037 Pulse start repeatedly during a len=10 transfer -> exactly one transfer of 24 SCLK periods and one done pulse.
REQ-038 Assert rst 10 cycles into a len=11 transfer -> CS=1 and SCLK=0 the same cycle, no done pulse, data_rx=0; a subsequent 0x5A loopback transfer returns 0x0000005A.
REQ-039 Mode 2 (CPOL=1, CPHA=0), len=00, data_tx=0xFF, MISO tied 0 -> data_rx=0x00000000, SCLK idle high before and after CS.
